// File: rtl/ibex_pkg_pext.sv
// Shared types for the P-extension datapath: configuration, Zpn opcodes and
// the operand-stage FSM state.
package ibex_pkg_pext;

    typedef enum logic [1:0] {
        RV32PNone,
        RV32PZpn,
        RV32PFull
    } rv32p_e;

    typedef enum logic [4:0] {
        ZPN_ADD8,
        ZPN_ADD16,
        ZPN_SUB8,
        ZPN_SUB16,
        ZPN_KADD8,
        ZPN_KADD16,
        ZPN_SMAQA,
        ZPN_UMAQA,
        ZPN_KMMAC,
        ZPN_INSB,
        ZPN_PBSADA
    } zpn_op_e;

    typedef enum logic {
        OPS_IDLE,
        OPS_ISSUE_RD
    } pext_opstage_e;

endpackage

// File: rtl/ibex_pext_fwd_mux.sv
// Per-read-port operand select: x0 forces zero, otherwise the writeback port
// bypasses the register file when it targets the same address.
module ibex_pext_fwd_mux #(
    parameter bit WbForward = 1'b1
) (
    input  logic [4:0]  addr_i,
    input  logic [31:0] rdata_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] data_o
);

    logic hit;

    assign hit = WbForward && we_i && (waddr_i == addr_i);

    always_comb begin
        data_o = rdata_i;
        if (addr_i == 5'd0) begin
            data_o = 32'd0;
        end else if (hit) begin
            data_o = wdata_i;
        end
    end

endmodule

// File: rtl/ibex_pext_operand_stage.sv
// Operand collection for P-extension instructions: two-source ops issue in the
// decode cycle, rd-reading ops spend one extra cycle fetching rd into rd_q.
//
// state        | meaning
// OPS_IDLE     | accept a new instruction; rd fetch happens here for 3-op forms
// OPS_ISSUE_RD | rd held in rd_q, rs1/rs2 read, all three operands to EX
module ibex_pext_operand_stage
    import ibex_pkg_pext::*;
#(
    parameter rv32p_e RV32P     = RV32PNone,
    parameter bit     WbForward = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic        needs_rd_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic [4:0]  rf_raddr_a_o,
    output logic [4:0]  rf_raddr_b_o,
    input  logic [31:0] rf_rdata_a_i,
    input  logic [31:0] rf_rdata_b_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_wdata_i,
    output logic [31:0] operand_a_o,
    output logic [31:0] operand_b_o,
    output logic [31:0] operand_rd_o,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic        multicycle_o
);

    localparam bit HasP = (RV32P != RV32PNone);

    pext_opstage_e state_q;
    logic [31:0]   rd_q;
    logic          needs_rd;
    logic          rd_fetch_sel;
    logic [31:0]   fwd_a;
    logic [31:0]   fwd_b;

    assign needs_rd     = HasP && needs_rd_i;
    assign rd_fetch_sel = (state_q == OPS_IDLE) && instr_valid_i && needs_rd;

    ibex_pext_fwd_mux #(.WbForward(WbForward)) u_fwd_a (
        .addr_i  (rf_raddr_a_o),
        .rdata_i (rf_rdata_a_i),
        .we_i    (wb_we_i),
        .waddr_i (wb_waddr_i),
        .wdata_i (wb_wdata_i),
        .data_o  (fwd_a)
    );

    ibex_pext_fwd_mux #(.WbForward(WbForward)) u_fwd_b (
        .addr_i  (rf_raddr_b_o),
        .rdata_i (rf_rdata_b_i),
        .we_i    (wb_we_i),
        .waddr_i (wb_waddr_i),
        .wdata_i (wb_wdata_i),
        .data_o  (fwd_b)
    );

    assign rf_raddr_a_o = rd_fetch_sel ? rd_addr_i : rs1_addr_i;
    assign rf_raddr_b_o = rs2_addr_i;
    assign operand_a_o  = fwd_a;
    assign operand_b_o  = fwd_b;

    always_comb begin
        ex_valid_o    = 1'b0;
        instr_ready_o = 1'b0;
        multicycle_o  = 1'b0;
        operand_rd_o  = 32'd0;
        if (!rst_i) begin
            unique case (state_q)
                OPS_IDLE: begin
                    if (flush_i) begin
                        instr_ready_o = 1'b1;
                    end else if (instr_valid_i && needs_rd) begin
                        multicycle_o = 1'b1;
                    end else if (instr_valid_i) begin
                        ex_valid_o    = 1'b1;
                        instr_ready_o = ex_ready_i;
                    end
                end
                OPS_ISSUE_RD: begin
                    operand_rd_o = rd_q;
                    if (flush_i) begin
                        instr_ready_o = 1'b1;
                    end else begin
                        ex_valid_o    = 1'b1;
                        instr_ready_o = ex_ready_i;
                    end
                end
                default: ;
            endcase
        end
    end

    if (HasP) begin : g_fsm
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= OPS_IDLE;
                rd_q    <= 32'd0;
            end else begin
                unique case (state_q)
                    OPS_IDLE: begin
                        if (instr_valid_i && needs_rd && !flush_i) begin
                            state_q <= OPS_ISSUE_RD;
                            rd_q    <= fwd_a;
                        end
                    end
                    OPS_ISSUE_RD: begin
                        if (flush_i || ex_ready_i) begin
                            state_q <= OPS_IDLE;
                        end
                        // rd may be written back while EX stalls us
                        if (wb_we_i && (wb_waddr_i == rd_addr_i) && (rd_addr_i != 5'd0)) begin
                            rd_q <= wb_wdata_i;
                        end
                    end
                    default: state_q <= OPS_IDLE;
                endcase
            end
        end
    end else begin : g_no_fsm
        logic unused_rd_sig;
        assign unused_rd_sig = ^{clk_i, needs_rd_i, rd_addr_i};
        assign state_q = OPS_IDLE;
        assign rd_q    = 32'd0;
    end

endmodule
